// File: rtl/bcd_pkg.sv
// Shared definitions for the binary-to-BCD converter and its display consumers.
package bcd_pkg;

   // Converter sequencing states.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_LOAD  = 2'd2
   } state_t;

   // Width of one packed BCD digit.
   localparam int BCD_DIGIT_W = 4;

   // Digits at or above this value are corrected by +3 before each shift.
   localparam logic [BCD_DIGIT_W-1:0] ADD3_THRESH = 4'd5;

   // Digit code that 7-segment decoders render as an unlit digit (used on overflow).
   localparam logic [BCD_DIGIT_W-1:0] BLANK_DIGIT = 4'hF;

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Start/busy/done handshake and data bus of the binary-to-BCD converter.
interface bin_to_bcd_seq_if #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
);
   logic                  start;
   logic [WIDTH-1:0]      bin;
   logic                  busy;
   logic                  done;
   logic [4*DIGITS-1:0]   bcd;
   logic                  ovf;

   // Requester side: issues conversions and consumes results.
   modport master (output start, output bin, input busy, input done, input bcd, input ovf);

   // Converter side.
   modport slave  (input start, input bin, output busy, output done, output bcd, output ovf);
endinterface

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a digit of 5..9 gets +3 so that the
// following left shift carries correctly into the next decimal digit.
module bcd_add3
   import bcd_pkg::*;
(
   input  logic [BCD_DIGIT_W-1:0] i_digit,
   output logic [BCD_DIGIT_W-1:0] o_digit
);

   assign o_digit = (i_digit >= ADD3_THRESH) ? (i_digit + 4'd3) : i_digit;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, one operand bit per clock (shift-and-add-3).
// Result and overflow flag are published only on completion, so the display
// side never sees partial digits.
module bin_to_bcd_seq
   import bcd_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic            Clock,
   input  logic            Resetn,
   bin_to_bcd_seq_if.slave bus
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam int SCR_W = BCD_DIGIT_W * DIGITS;
   localparam int CAT_W = SCR_W + WIDTH;

   state_t             r_state;
   state_t             w_state_next;
   logic [CNT_W-1:0]   r_cnt;
   logic [WIDTH-1:0]   r_shift;
   logic [SCR_W-1:0]   r_scratch;
   logic [SCR_W-1:0]   w_adj;
   logic [SCR_W-1:0]   r_bcd;
   logic               r_ovf_acc;
   logic               r_ovf;
   logic               r_done;
   logic [CAT_W-1:0]   w_cat;
   logic [CAT_W-1:0]   w_cat_shl;

   // Per-digit +3 correction of the scratch register ahead of the shift.
   generate
      for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
         bcd_add3 u_add3 (
            .i_digit (r_scratch[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .o_digit (w_adj[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
         );
      end
   endgenerate

   // The top bit of the corrected digits is what falls off the top digit
   // on this shift; it marks a value of 10^DIGITS or more.
   assign w_cat     = {w_adj, r_shift};
   assign w_cat_shl = {w_cat[CAT_W-2:0], 1'b0};

   assign bus.busy = (r_state != ST_IDLE);
   assign bus.done = r_done;
   assign bus.bcd  = r_bcd;
   assign bus.ovf  = r_ovf;

   // State register.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) r_state <= ST_IDLE;
      else         r_state <= w_state_next;
   end

   // Next-state logic: accept in IDLE, shift WIDTH times, then one publish cycle.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:  if (bus.start) w_state_next = ST_SHIFT;
         ST_SHIFT: if (r_cnt == CNT_W'(1)) w_state_next = ST_LOAD;
         ST_LOAD:  w_state_next = ST_IDLE;
         default:  w_state_next = ST_IDLE;
      endcase
   end

   // Datapath: operand capture, shift/adjust steps, result publish and done pulse.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         r_cnt     <= '0;
         r_shift   <= '0;
         r_scratch <= '0;
         r_ovf_acc <= 1'b0;
         r_bcd     <= '0;
         r_ovf     <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_done <= (r_state == ST_LOAD);
         case (r_state)
            ST_IDLE: begin
               if (bus.start) begin
                  r_shift   <= bus.bin;
                  r_scratch <= '0;
                  r_ovf_acc <= 1'b0;
                  r_cnt     <= CNT_W'(WIDTH);
               end
            end
            ST_SHIFT: begin
               r_scratch <= w_cat_shl[CAT_W-1:WIDTH];
               r_shift   <= w_cat_shl[WIDTH-1:0];
               if (w_cat[CAT_W-1]) r_ovf_acc <= 1'b1;
               r_cnt     <= r_cnt - CNT_W'(1);
            end
            ST_LOAD: begin
               r_bcd <= r_scratch;
               r_ovf <= r_ovf_acc;
            end
            default: ;
         endcase
      end
   end

endmodule
